// File: rtl/risc_pkg.sv
// Opcodes, instruction field positions and status bit indices
// shared by the three-stage RISC pipeline.
package risc_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_ADD    = 4'h1,
    OP_SUB    = 4'h2,
    OP_AND    = 4'h3,
    OP_OR     = 4'h4,
    OP_XOR    = 4'h5,
    OP_SHL1   = 4'h6,
    OP_SHR1   = 4'h7,
    OP_LDI    = 4'h8,
    OP_LD     = 4'h9,
    OP_ST     = 4'hA,
    OP_BZ     = 4'hB,
    OP_JMP    = 4'hC,
    OP_RSVD_D = 4'hD,
    OP_RSVD_E = 4'hE,
    OP_HALT   = 4'hF
  } op_e;

  localparam int F_OP_MSB  = 15;
  localparam int F_OP_LSB  = 12;
  localparam int F_RD_MSB  = 11;
  localparam int F_RD_LSB  = 9;
  localparam int F_RS_MSB  = 8;
  localparam int F_RS_LSB  = 6;
  localparam int F_RT_MSB  = 5;
  localparam int F_RT_LSB  = 3;
  localparam int F_IMM_MSB = 8;
  localparam int F_IMM_LSB = 0;

  localparam int ST_C     = 0;
  localparam int ST_Z     = 1;
  localparam int ST_N     = 2;
  localparam int ST_HALT  = 3;
  localparam int ST_STALL = 4;
  localparam int ST_BR    = 5;
  localparam int ST_FLUSH = 6;

  localparam logic [15:0] INSN_NOP = 16'h0000;

  function automatic logic is_alu(input op_e op);
    return (op >= OP_ADD) && (op <= OP_SHR1);
  endfunction

endpackage

// File: rtl/risc_alu.sv
// Combinational ALU for opcodes ADD..SHR1; carry doubles as borrow on SUB
// and as the shifted-out bit on the single-bit shifts.
module risc_alu
  import risc_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  op_e               i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_res,
  output logic              o_n,
  output logic              o_z,
  output logic              o_c
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_dif;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_dif = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_res = '0;
    o_c   = 1'b0;
    case (i_op)
      OP_ADD:  {o_c, o_res} = w_sum;
      OP_SUB:  {o_c, o_res} = w_dif;
      OP_AND:  o_res = i_a & i_b;
      OP_OR:   o_res = i_a | i_b;
      OP_XOR:  o_res = i_a ^ i_b;
      OP_SHL1: begin
        o_res = {i_a[DATA_W-2:0], 1'b0};
        o_c   = i_a[DATA_W-1];
      end
      OP_SHR1: begin
        o_res = {1'b0, i_a[DATA_W-1:1]};
        o_c   = i_a[0];
      end
      default: ;
    endcase
  end

  assign o_n = o_res[DATA_W-1];
  assign o_z = (o_res == '0);

endmodule

// File: rtl/risc_pipe_core.sv
// Three-stage (IF / EX / MW) RISC core with MW->EX forwarding, one-bubble
// redirects and a ready-handshaked data port that freezes the pipe.
module risc_pipe_core
  import risc_pkg::*;
#(
  parameter int                DATA_W   = 128,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] D_out,
  input  logic [DATA_W-1:0] D_in,
  output logic              mem_req,
  output logic              mw_en,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] Alu_Out,
  output logic [7:0]        status
);

  logic [DATA_W-1:0] r_regs [8];
  logic [ADDR_W-1:0] r_pc, r_pc_ex;
  logic [15:0]       r_ir;
  logic              r_halted;
  logic              r_n, r_z, r_c;
  logic [DATA_W-1:0] r_alu_out;

  logic              r_mw_vld;
  op_e               r_mw_op;
  logic [2:0]        r_mw_rd;
  logic [DATA_W-1:0] r_mw_res;
  logic [ADDR_W-1:0] r_mw_addr;
  logic [DATA_W-1:0] r_mw_data;

  op_e               w_op;
  logic [2:0]        w_rd, w_rs, w_rt;
  logic [8:0]        w_imm;
  logic              w_mw_wr, w_mem_op, w_stall;
  logic [DATA_W-1:0] w_mw_wval;
  logic [DATA_W-1:0] w_rs_val, w_rt_val, w_rd_val;
  logic [DATA_W-1:0] w_alu_res, w_ldi_val, w_ex_res;
  logic              w_alu_n, w_alu_z, w_alu_c;
  logic              w_is_alu, w_ex_vld, w_halt_ex, w_redirect;
  logic [ADDR_W-1:0] w_target;

  assign w_op  = op_e'(r_ir[F_OP_MSB:F_OP_LSB]);
  assign w_rd  = r_ir[F_RD_MSB:F_RD_LSB];
  assign w_rs  = r_ir[F_RS_MSB:F_RS_LSB];
  assign w_rt  = r_ir[F_RT_MSB:F_RT_LSB];
  assign w_imm = r_ir[F_IMM_MSB:F_IMM_LSB];

  // MW result as seen by EX: a completing load forwards straight from D_in.
  assign w_mw_wr   = r_mw_vld && (is_alu(r_mw_op) || r_mw_op == OP_LDI || r_mw_op == OP_LD);
  assign w_mw_wval = (r_mw_op == OP_LD) ? D_in : r_mw_res;
  assign w_mem_op  = r_mw_vld && (r_mw_op == OP_LD || r_mw_op == OP_ST);
  assign w_stall   = w_mem_op && !mem_ready;

  assign w_rs_val = (w_mw_wr && r_mw_rd == w_rs) ? w_mw_wval : r_regs[w_rs];
  assign w_rt_val = (w_mw_wr && r_mw_rd == w_rt) ? w_mw_wval : r_regs[w_rt];
  assign w_rd_val = (w_mw_wr && r_mw_rd == w_rd) ? w_mw_wval : r_regs[w_rd];

  risc_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op  (w_op),
    .i_a   (w_rs_val),
    .i_b   (w_rt_val),
    .o_res (w_alu_res),
    .o_n   (w_alu_n),
    .o_z   (w_alu_z),
    .o_c   (w_alu_c)
  );

  assign w_is_alu  = is_alu(w_op);
  assign w_ldi_val = DATA_W'($signed(w_imm));
  assign w_ex_res  = (w_op == OP_LDI) ? w_ldi_val : w_alu_res;
  assign w_ex_vld  = w_is_alu || w_op == OP_LDI || w_op == OP_LD || w_op == OP_ST;
  assign w_halt_ex = (w_op == OP_HALT);

  // A branch waiting behind a stalled access resolves only once MW moves.
  assign w_redirect = !w_stall &&
                      ((w_op == OP_BZ && w_rd_val == '0) || w_op == OP_JMP);
  assign w_target   = (w_op == OP_JMP) ? w_rs_val[ADDR_W-1:0]
                                       : r_pc_ex + ADDR_W'(1) + ADDR_W'($signed(w_imm));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_pc_ex  <= RESET_PC;
      r_ir     <= INSN_NOP;
      r_halted <= 1'b0;
    end else if (!w_stall) begin
      if (w_halt_ex) begin
        r_halted <= 1'b1;
      end else if (w_redirect) begin
        r_pc <= w_target;
        r_ir <= INSN_NOP;
      end else begin
        r_pc    <= r_pc + ADDR_W'(1);
        r_ir    <= imem_rdata;
        r_pc_ex <= r_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mw_vld  <= 1'b0;
      r_mw_op   <= OP_NOP;
      r_mw_rd   <= '0;
      r_mw_res  <= '0;
      r_mw_addr <= '0;
      r_mw_data <= '0;
      r_n       <= 1'b0;
      r_z       <= 1'b0;
      r_c       <= 1'b0;
      r_alu_out <= '0;
    end else if (!w_stall) begin
      r_mw_vld  <= w_ex_vld;
      r_mw_op   <= w_op;
      r_mw_rd   <= w_rd;
      r_mw_res  <= w_ex_res;
      r_mw_addr <= w_rs_val[ADDR_W-1:0];
      r_mw_data <= w_rd_val;
      if (w_is_alu) begin
        r_n <= w_alu_n;
        r_z <= w_alu_z;
        r_c <= w_alu_c;
      end
      if (w_is_alu || w_op == OP_LDI) r_alu_out <= w_ex_res;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else if (w_mw_wr && !w_stall) begin
      r_regs[r_mw_rd] <= w_mw_wval;
    end
  end

  assign imem_addr = r_pc;
  assign Address   = r_mw_addr;
  assign D_out     = r_mw_data;
  assign mem_req   = w_mem_op;
  assign mw_en     = w_mem_op && (r_mw_op == OP_ST);
  assign Alu_Out   = r_alu_out;

  always_comb begin
    status           = '0;
    status[ST_C]     = r_c;
    status[ST_Z]     = r_z;
    status[ST_N]     = r_n;
    status[ST_HALT]  = r_halted;
    status[ST_STALL] = w_stall;
    status[ST_BR]    = w_redirect;
    status[ST_FLUSH] = w_redirect;
  end

endmodule

// File: tb/tb_risc_pipe_core.sv
// Directed programs against an instruction-level model of the core, compared
// every cycle, plus hand-computed end-of-program expectations.
module tb_risc_pipe_core;
  localparam int DW = 128;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] imem_addr, Address;
  logic [15:0]   imem_rdata;
  logic [DW-1:0] D_out, D_in, Alu_Out;
  logic          mem_req, mw_en, mem_ready;
  logic [7:0]    status;

  risc_pipe_core #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .Address(Address), .D_out(D_out), .D_in(D_in), .mem_req(mem_req),
    .mw_en(mw_en), .mem_ready(mem_ready), .Alu_Out(Alu_Out), .status(status)
  );

  always #5 clk = ~clk;

  logic [15:0]   rom  [256];
  logic [DW-1:0] dmem [256];
  int            lat = 0;
  int            wcnt = 0;
  bit            spur = 1'b0;
  bit            chk_en = 1'b0;
  int            nchk = 0;
  int            nerr = 0;

  assign imem_rdata = rom[imem_addr[7:0]];
  assign D_in       = dmem[Address[7:0]];
  assign mem_ready  = (mem_req && wcnt >= lat) || (!mem_req && spur);

  // Data memory: counts waiting cycles, commits stores on the accepting edge.
  initial forever begin
    @(posedge clk);
    if (mem_req && mem_ready && mw_en) dmem[Address[7:0]] <= D_out;
    wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- instruction-level model ----------------
  logic [DW-1:0] mR [8];
  logic [AW-1:0] mpc, mpcx;
  logic [15:0]   mir;
  bit            mhalt, mN, mZ, mC;
  logic [DW-1:0] malu;
  bit            mw_v;
  logic [3:0]    mw_op;
  logic [2:0]    mw_rd;
  logic [DW-1:0] mw_val, mw_data;
  logic [AW-1:0] mw_addr;

  function automatic logic [DW-1:0] rv(input logic [2:0] i);
    if (mw_v && (mw_op inside {[1:9]}) && mw_rd == i) return (mw_op == 4'h9) ? D_in : mw_val;
    return mR[i];
  endfunction
  function automatic bit m_memop();
    return mw_v && (mw_op == 4'h9 || mw_op == 4'hA);
  endfunction
  function automatic bit m_stall();
    return m_memop() && !mem_ready;
  endfunction
  function automatic bit m_taken();
    return !m_stall() && ((mir[15:12] == 4'hB && rv(mir[11:9]) == '0) || mir[15:12] == 4'hC);
  endfunction

  task automatic alu(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     output logic [DW-1:0] r, output bit c);
    logic [DW:0] w;
    r = '0; c = 0;
    case (op)
      4'h1: begin w = {1'b0, a} + {1'b0, b}; r = w[DW-1:0]; c = w[DW]; end
      4'h2: begin r = a - b; c = (a < b); end
      4'h3: r = a & b;
      4'h4: r = a | b;
      4'h5: r = a ^ b;
      4'h6: begin r = a << 1; c = a[DW-1]; end
      4'h7: begin r = a >> 1; c = a[0]; end
      default: ;
    endcase
  endtask

  initial begin : mdl
    logic [3:0]    op;
    logic [DW-1:0] a, b, d, r;
    logic [AW-1:0] tgt;
    bit            c, tk;
    forever begin
      @(posedge clk);
      if (reset) begin
        foreach (mR[i]) mR[i] = '0;
        mpc = '0; mpcx = '0; mir = '0; mhalt = 0; mN = 0; mZ = 0; mC = 0; malu = '0;
        mw_v = 0; mw_op = '0; mw_rd = '0; mw_val = '0; mw_addr = '0; mw_data = '0;
      end else if (!m_stall()) begin
        op = mir[15:12];
        a = rv(mir[8:6]); b = rv(mir[5:3]); d = rv(mir[11:9]);
        tk = m_taken();
        tgt = (op == 4'hC) ? a[AW-1:0] : mpcx + 16'd1 + {{(AW-9){mir[8]}}, mir[8:0]};
        if (mw_v && (mw_op inside {[1:9]})) mR[mw_rd] = rv(mw_rd);
        r = {{(DW-9){mir[8]}}, mir[8:0]};
        c = 0;
        if (op inside {[1:7]}) begin
          alu(op, a, b, r, c);
          mN = r[DW-1]; mZ = (r == '0); mC = c;
        end
        if (op inside {[1:8]}) malu = r;
        mw_v = (op inside {[1:10]}); mw_op = op; mw_rd = mir[11:9];
        mw_val = r; mw_addr = a[AW-1:0]; mw_data = d;
        if (op == 4'hF) mhalt = 1;
        else if (tk) begin mpc = tgt; mir = '0; end
        else begin mir = rom[mpc[7:0]]; mpcx = mpc; mpc = mpc + 16'd1; end
      end
    end
  end

  // Per-cycle comparison of every observable output against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("imem_addr", DW'(imem_addr), DW'(mpc));
      chk("mem_req", DW'(mem_req), DW'(m_memop()));
      if (m_memop()) begin
        chk("mw_en", DW'(mw_en), DW'(mw_op == 4'hA));
        chk("Address", DW'(Address), DW'(mw_addr));
        if (mw_op == 4'hA) chk("D_out", D_out, mw_data);
      end
      chk("Alu_Out", Alu_Out, malu);
      chk("status", DW'(status),
          DW'({1'b0, m_taken(), m_taken(), m_stall(), mhalt, mN, mZ, mC}));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [15:0] rr(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 3'b000};
  endfunction
  function automatic logic [15:0] ri(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [8:0] imm);
    return {op, rd, imm};
  endfunction

  task automatic clr_rom();
    foreach (rom[i]) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run(input int maxc, output int hc, output int bc, output int sc, output int bf);
    hc = 0; bc = 0; sc = 0; bf = 0;
    for (int cyc = 1; cyc <= maxc; cyc++) begin
      @(negedge clk);
      if (status[4]) sc++;
      if (status[5]) begin bc++; if (bf == 0) bf = cyc; end
      if (status[3]) begin hc = cyc; break; end
    end
    if (hc == 0) begin
      nchk++; nerr++;
      $display("FAIL run_timeout halted=0 required=1");
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int hc, bc, sc, bf;
    bit seen;
    logic [DW-1:0] all_m2;
    all_m2 = ~128'd1;
    foreach (dmem[i]) dmem[i] = '0;
    clr_rom();
    @(posedge clk);
    #1 chk_en = 1'b1;

    // Back-to-back LDI/LDI/ADD through forwarding
    clr_rom();
    rom[0] = ri(4'h8, 3'd1, 9'd5); rom[1] = ri(4'h8, 3'd2, 9'd3);
    rom[2] = rr(4'h1, 3'd3, 3'd1, 3'd2); rom[3] = 16'hF000;
    do_reset();
    run(40, hc, bc, sc, bf);
    chk("t1_halt_cycle", DW'(hc), DW'(6));
    chk("t1_alu", Alu_Out, DW'(8));
    chk("t1_status", DW'(status), DW'(8'h08));
    chk("t1_model_alu", malu, DW'(8));

    // SUB to zero; stray mem_ready with no request must be ignored
    clr_rom(); spur = 1'b1;
    rom[0] = ri(4'h8, 3'd1, 9'd0); rom[1] = rr(4'h2, 3'd2, 3'd1, 3'd1); rom[2] = 16'hF000;
    do_reset();
    run(40, hc, bc, sc, bf);
    spur = 1'b0;
    chk("t2_halt_cycle", DW'(hc), DW'(5));
    chk("t2_status", DW'(status), DW'(8'h0A));
    chk("t2_stalls", DW'(sc), DW'(0));

    // -1 + -1: carry out and negative result
    clr_rom();
    rom[0] = ri(4'h8, 3'd1, 9'h1FF); rom[1] = rr(4'h1, 3'd2, 3'd1, 3'd1); rom[2] = 16'hF000;
    do_reset();
    run(40, hc, bc, sc, bf);
    chk("t3_alu", Alu_Out, all_m2);
    chk("t3_status", DW'(status), DW'(8'h0D));
    chk("t3_model_alu", malu, all_m2);

    // Taken BZ at PC 4 (+3 -> 8), then a not-taken BZ
    clr_rom();
    rom[0] = ri(4'h8, 3'd1, 9'd0);  rom[4]  = ri(4'hB, 3'd1, 9'd3);
    rom[5] = ri(4'h8, 3'd6, 9'd1);  rom[6]  = ri(4'h8, 3'd6, 9'd2);
    rom[7] = ri(4'h8, 3'd6, 9'd2);  rom[8]  = ri(4'h8, 3'd7, 9'd7);
    rom[9] = ri(4'hB, 3'd7, 9'd1);  rom[10] = ri(4'h8, 3'd6, 9'd9);
    rom[11] = 16'hF000;
    do_reset();
    run(60, hc, bc, sc, bf);
    chk("t4_br_cycle", DW'(bf), DW'(6));
    chk("t4_br_count", DW'(bc), DW'(1));
    chk("t4_halt_cycle", DW'(hc), DW'(12));
    chk("t4_alu", Alu_Out, DW'(9));

    // Load with 3 wait cycles feeding a dependent ADD
    clr_rom(); lat = 3; dmem[8'h10] = 128'h1234;
    rom[0] = ri(4'h8, 3'd1, 9'h10); rom[1] = rr(4'h9, 3'd4, 3'd1, 3'd0);
    rom[2] = rr(4'h1, 3'd5, 3'd4, 3'd4); rom[3] = 16'hF000;
    do_reset();
    run(60, hc, bc, sc, bf);
    chk("t5_stalls", DW'(sc), DW'(3));
    chk("t5_halt_cycle", DW'(hc), DW'(9));
    chk("t5_alu", Alu_Out, DW'(128'h2468));

    // JMP over a store, then ST + HALT with a slow memory
    clr_rom(); lat = 2;
    rom[0] = ri(4'h8, 3'd3, 9'd4);        rom[1] = rr(4'hC, 3'd0, 3'd3, 3'd0);
    rom[2] = rr(4'hA, 3'd3, 3'd3, 3'd0);  rom[3] = rr(4'hA, 3'd3, 3'd3, 3'd0);
    rom[4] = ri(4'h8, 3'd1, 9'h20);       rom[5] = ri(4'h8, 3'd2, 9'h55);
    rom[6] = rr(4'hA, 3'd2, 3'd1, 3'd0);  rom[7] = 16'hF000;
    do_reset();
    run(60, hc, bc, sc, bf);
    chk("t6_jmp_cycle", DW'(bf), DW'(3));
    chk("t6_stalls", DW'(sc), DW'(2));
    chk("t6_halt_cycle", DW'(hc), DW'(11));
    chk("t6_store", dmem[8'h20], DW'(128'h55));
    chk("t6_flushed_store", dmem[8'h04], DW'(0));
    chk("t6_pc_frozen", DW'(imem_addr), DW'(8));

    // Reset while a load is outstanding
    clr_rom(); lat = 20;
    rom[0] = ri(4'h8, 3'd1, 9'h10); rom[1] = rr(4'h9, 3'd4, 3'd1, 3'd0); rom[2] = 16'hF000;
    do_reset();
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = mem_req;
    end
    chk("t7_req_seen", DW'(seen), DW'(1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t7_req_dropped", DW'(mem_req), DW'(0));
    chk("t7_pc_reset", DW'(imem_addr), DW'(0));
    chk("t7_status", DW'(status), DW'(0));
    chk("t7_alu", Alu_Out, DW'(0));
    lat = 0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
